key_conditioner: RTL and testbench



---
 rtl/key_conditioner_lane.sv | 107 ++++++++++
 rtl/key_conditioner.sv | 39 +++
 tb/tb_key_conditioner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_lane.sv
// Single key lane: 2-flop synchronizer, counter debouncer, press/release
// pulses and optional hold-to-repeat pulses.
// Ports: clk, rst_n (async, active-low), key (raw, async), key_stable,
//        key_press, key_release, key_repeat, key_event (press | repeat).
module key_conditioner_lane #(
  parameter int unsigned debounce_cycles      = 500000,
  parameter int unsigned repeat_delay_cycles  = 25000000,
  parameter int unsigned repeat_period_cycles = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_stable,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_event
);

  localparam int unsigned DBW = $clog2(debounce_cycles + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(debounce_cycles - 1);

  logic           sync1;
  logic           sync2;
  logic [DBW-1:0] db_cnt;
  logic           accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Level change is accepted on the edge that completes the stable run.
  assign accept = (sync2 != key_stable) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stable  <= 1'b0;
      db_cnt      <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= accept & sync2;
      key_release <= accept & ~sync2;
      if ((sync2 == key_stable) || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
      if (accept) begin
        key_stable <= sync2;
      end
    end
  end

  if (repeat_delay_cycles == 0) begin : g_no_rpt
    assign key_repeat = 1'b0;
  end else begin : g_rpt
    localparam int unsigned RPT_MAX = (repeat_delay_cycles > repeat_period_cycles) ?
                                      repeat_delay_cycles : repeat_period_cycles;
    localparam int unsigned RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(repeat_delay_cycles - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(repeat_period_cycles - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_q;
    logic          rpt_hit;

    // rpt_first selects the initial delay; afterwards the period applies.
    assign rpt_hit = (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
        rpt_q     <= 1'b0;
      end else if (accept) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
        rpt_q     <= 1'b0;
      end else if (key_stable) begin
        if (rpt_hit) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b0;
          rpt_q     <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + RW'(1);
          rpt_q   <= 1'b0;
        end
      end else begin
        rpt_cnt <= '0;
        rpt_q   <= 1'b0;
      end
    end

    assign key_repeat = rpt_q;
  end

  assign key_event = key_press | key_repeat;

endmodule

// File: rtl/key_conditioner.sv
// Conditions w_key raw key inputs into clean debounced levels and
// single-cycle press/release/repeat events.
// Ports: clk, rst_n (async, active-low), key[w_key] raw levels;
//        key_stable, key_press, key_release, key_repeat, key_event per lane.
module key_conditioner #(
  parameter int unsigned clk_mhz              = 50,
  parameter int unsigned w_key                = 4,
  parameter int unsigned debounce_cycles      = clk_mhz * 1000 * 10,
  parameter int unsigned repeat_delay_cycles  = clk_mhz * 1000 * 500,
  parameter int unsigned repeat_period_cycles = clk_mhz * 1000 * 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [w_key-1:0] key,
  output logic [w_key-1:0] key_stable,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic [w_key-1:0] key_repeat,
  output logic [w_key-1:0] key_event
);

  for (genvar i = 0; i < int'(w_key); i++) begin : g_lane
    key_conditioner_lane #(
      .debounce_cycles     (debounce_cycles),
      .repeat_delay_cycles (repeat_delay_cycles),
      .repeat_period_cycles(repeat_period_cycles)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .key_stable (key_stable[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i]),
      .key_event  (key_event[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] key   = '0;

  logic [W-1:0] ks [2];
  logic [W-1:0] kp [2];
  logic [W-1:0] kr [2];
  logic [W-1:0] krp[2];
  logic [W-1:0] kev[2];

  int total = 0;
  int bad   = 0;

  int nr_press0 = 0;
  int nr_rpt    = 0;
  int rpt0_cnt  = 0;
  int any1_cnt  = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .clk_mhz(50), .w_key(W), .debounce_cycles(DB),
    .repeat_delay_cycles(RD), .repeat_period_cycles(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_stable(ks[0]), .key_press(kp[0]), .key_release(kr[0]),
    .key_repeat(krp[0]), .key_event(kev[0])
  );

  key_conditioner #(
    .clk_mhz(50), .w_key(W), .debounce_cycles(DB),
    .repeat_delay_cycles(0), .repeat_period_cycles(RP)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_stable(ks[1]), .key_press(kp[1]), .key_release(kr[1]),
    .key_repeat(krp[1]), .key_event(kev[1])
  );

  // Reference: key is seen by the debouncer two edges late; the level is
  // accepted after DB consecutive differing edges; repeats fall at
  // age == delay + n*period measured in edges since the press.
  bit m_kd1[W];
  bit m_kd2[W];
  bit m_stab[2][W];
  int m_run[2][W];
  int m_age[2][W];
  bit e_p[2][W];
  bit e_r[2][W];
  bit e_rp[2][W];
  int dly[2] = '{RD, 0};

  function automatic void model_clear();
    for (int l = 0; l < int'(W); l++) begin
      m_kd1[l] = 0;
      m_kd2[l] = 0;
      for (int i = 0; i < 2; i++) begin
        m_stab[i][l] = 0; m_run[i][l] = 0; m_age[i][l] = 0;
        e_p[i][l] = 0; e_r[i][l] = 0; e_rp[i][l] = 0;
      end
    end
  endfunction

  function automatic void model_step(logic [W-1:0] k);
    for (int l = 0; l < int'(W); l++) begin
      bit seen;
      seen     = m_kd2[l];
      m_kd2[l] = m_kd1[l];
      m_kd1[l] = k[l];
      for (int i = 0; i < 2; i++) begin
        e_p[i][l] = 0; e_r[i][l] = 0; e_rp[i][l] = 0;
        if (seen != m_stab[i][l]) begin
          m_run[i][l]++;
          if (m_run[i][l] == int'(DB)) begin
            m_stab[i][l] = seen;
            m_run[i][l]  = 0;
            if (seen) begin
              e_p[i][l]   = 1;
              m_age[i][l] = 0;
            end else begin
              e_r[i][l] = 1;
            end
          end
        end else begin
          m_run[i][l] = 0;
        end
        if (m_stab[i][l] && !e_p[i][l]) begin
          m_age[i][l]++;
          if (dly[i] != 0 && m_age[i][l] >= dly[i] &&
              ((m_age[i][l] - dly[i]) % int'(RP)) == 0)
            e_rp[i][l] = 1;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] xs, xp, xr, xrp;
      for (int l = 0; l < int'(W); l++) begin
        xs[l] = m_stab[i][l]; xp[l] = e_p[i][l];
        xr[l] = e_r[i][l];    xrp[l] = e_rp[i][l];
      end
      check($sformatf("stable%0d", i), 32'(ks[i]),  32'(xs));
      check($sformatf("press%0d", i),  32'(kp[i]),  32'(xp));
      check($sformatf("release%0d", i),32'(kr[i]),  32'(xr));
      check($sformatf("repeat%0d", i), 32'(krp[i]), 32'(xrp));
      check($sformatf("event%0d", i),  32'(kev[i]), 32'(xp | xrp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(key);
    else model_clear();
    #1;
    compare();
    nr_press0 += int'(kp[1][0]);
    nr_rpt    += int'(krp[1] != '0);
    rpt0_cnt  += int'(krp[0][0]);
    any1_cnt  += int'(kp[0][1] | kr[0][1] | ks[0][1]);
  endtask

  initial begin
    model_clear();
    // Reset with all keys held.
    rst_n = 1'b0;
    key   = 4'hF;
    repeat (3) tick();
    check("rst_out", 32'({ks[0], kp[0], kr[0], krp[0], kev[0]}), 32'h0);
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 5) check("rst_early", 32'(ks[0]), 32'h0);
      if (n == 6) begin
        check("rst_stable6", 32'(ks[0]), 32'hF);
        check("rst_press6",  32'(kp[0]), 32'hF);
      end
      if (n == 7) check("rst_press7", 32'(kp[0]), 32'h0);
    end
    key = '0;
    repeat (12) tick();

    // Clean press on lane 0 with long hold, then release.
    key[0]   = 1'b1;
    rpt0_cnt = 0;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (n == 6) check("press6", 32'(kp[0][0]), 32'h1);
      if (n == 7) check("press7", 32'(kp[0][0]), 32'h0);
      if (n == 26 || n == 34 || n == 42) check("rpt_at", 32'(krp[0][0]), 32'h1);
    end
    check("rpt_count", 32'(rpt0_cnt), 32'd3);
    key[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 6) check("release6", 32'(kr[0][0]), 32'h1);
      if (n == 7) check("stable_rel", 32'(ks[0][0]), 32'h0);
    end

    // Bounce on lane 1: never accepted.
    any1_cnt = 0;
    key[1] = 1'b1; repeat (2) tick();
    key[1] = 1'b0; repeat (2) tick();
    key[1] = 1'b1; repeat (2) tick();
    key[1] = 1'b0; repeat (12) tick();
    check("bounce_quiet", 32'(any1_cnt), 32'd0);

    // Simultaneous press on lanes 2 and 3, then reset mid-hold.
    key[3:2] = 2'b11;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 6) check("simul_press", 32'(kp[0]), 32'hC);
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    compare();
    check("midrst_out", 32'({ks[0], kp[0], kr[0], krp[0], kev[0]}), 32'h0);
    repeat (2) tick();
    key   = '0;
    rst_n = 1'b1;
    repeat (8) tick();

    // Long hold on the repeat-disabled instance.
    nr_press0 = 0;
    nr_rpt    = 0;
    key[0]    = 1'b1;
    repeat (100) tick();
    check("nr_press_once", 32'(nr_press0), 32'd1);
    check("nr_no_repeat", 32'(nr_rpt), 32'd0);
    key = '0;
    repeat (12) tick();

    // Random activity, alternating bouncy and slow phases.
    for (int n = 0; n < 2000; n++) begin
      int unsigned rate;
      rate = ((n / 200) % 2 == 0) ? 2 : 30;
      for (int l = 0; l < int'(W); l++)
        if ($urandom_range(0, rate) == 0) key[l] = ~key[l];
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
